// File: rtl/map_renderer_if.sv
// Framebuffer write port between the map renderer (master) and the framebuffer/VGA writer (slave).
interface map_renderer_if;
  logic [9:0]  wr_x;
  logic [8:0]  wr_y;
  logic [23:0] wr_color;
  logic        wr_valid;
  logic        wr_ready;

  modport master (output wr_x, wr_y, wr_color, wr_valid, input wr_ready);
  modport slave  (input wr_x, wr_y, wr_color, wr_valid, output wr_ready);
endinterface

// File: rtl/map_renderer.sv
// Raster-scans the screen and emits one framebuffer write per pixel, drawing the
// outlines of every rectangle in map_rom in WALL_COLOR over BG_COLOR.
module map_renderer #(
  parameter int          WIDTH      = 640,
  parameter int          HEIGHT     = 480,
  parameter int          NUM_RECTS  = 21,
  parameter logic [23:0] WALL_COLOR = 24'h0000FF,
  parameter logic [23:0] BG_COLOR   = 24'h000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [37:0]       map_rom [NUM_RECTS],
  map_renderer_if.master    wr,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {S_IDLE, S_DRAW, S_DONE} state_t;

  state_t     state, state_nxt;
  logic       accept;
  logic       last_px;
  logic       load;
  logic [9:0] x_nxt;
  logic [8:0] y_nxt;
  logic       hit_nxt;

  assign accept  = wr.wr_valid && wr.wr_ready;
  assign last_px = (wr.wr_x == 10'(WIDTH - 1)) && (wr.wr_y == 9'(HEIGHT - 1));
  assign load    = ((state == S_IDLE) && start) || accept;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_DRAW;
      S_DRAW:  if (accept && last_px) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    wr.wr_valid = (state == S_DRAW);
    busy        = (state == S_DRAW);
    done        = (state == S_DONE);
  end

  // Pixel that will be presented after the next load; (0,0) starts and ends a frame.
  always_comb begin
    x_nxt = '0;
    y_nxt = '0;
    if (state == S_DRAW) begin
      if (wr.wr_x == 10'(WIDTH - 1)) begin
        x_nxt = '0;
        y_nxt = last_px ? 9'd0 : wr.wr_y + 9'd1;
      end else begin
        x_nxt = wr.wr_x + 10'd1;
        y_nxt = wr.wr_y;
      end
    end
  end

  // Outline test on the upcoming pixel so its colour registers alongside its coordinates.
  // Corners fail both strict inequalities and are therefore excluded.
  always_comb begin
    hit_nxt = 1'b0;
    for (int i = 0; i < NUM_RECTS; i++) begin
      hit_nxt = hit_nxt
        | (((x_nxt == map_rom[i][37:28]) || (x_nxt == map_rom[i][18:9]))
           && (y_nxt > map_rom[i][27:19]) && (y_nxt < map_rom[i][8:0]))
        | (((y_nxt == map_rom[i][27:19]) || (y_nxt == map_rom[i][8:0]))
           && (x_nxt > map_rom[i][37:28]) && (x_nxt < map_rom[i][18:9]));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr.wr_x     <= '0;
      wr.wr_y     <= '0;
      wr.wr_color <= BG_COLOR;
    end else if (load) begin
      wr.wr_x     <= x_nxt;
      wr.wr_y     <= y_nxt;
      wr.wr_color <= ((state == S_DRAW) && last_px) ? BG_COLOR
                   : (hit_nxt ? WALL_COLOR : BG_COLOR);
    end
  end

endmodule

// File: tb/tb_map_renderer.sv
// Randomized scoreboard bench for map_renderer on a reduced screen, with a
// behavioural outline model producing the expected pixel stream.
module tb_map_renderer;

  localparam int          W    = 40;
  localparam int          H    = 44;
  localparam int          NR   = 4;
  localparam logic [23:0] WALL = 24'h0000FF;
  localparam logic [23:0] BG   = 24'h000000;
  localparam int          FRAME_BUDGET = 20000;

  typedef struct {
    int          x;
    int          y;
    logic [23:0] color;
    bit          last;
  } px_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [37:0] map_rom [NR];
  logic        busy, done;

  map_renderer_if wr_bus ();

  map_renderer #(
    .WIDTH(W), .HEIGHT(H), .NUM_RECTS(NR), .WALL_COLOR(WALL), .BG_COLOR(BG)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .map_rom(map_rom),
    .wr(wr_bus), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int  checks = 0;
  int  errors = 0;
  px_t exp_q [$];
  bit  expect_done = 0;
  int  done_count = 0;
  int  frames_done = 0;
  int  ready_mode = 0;
  int  rx0 [NR], ry0 [NR], rx1 [NR], ry1 [NR];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_rect(input int i, input int x0, input int y0, input int x1, input int y1);
    rx0[i] = x0; ry0[i] = y0; rx1[i] = x1; ry1[i] = y1;
    map_rom[i] = {10'(x0), 9'(y0), 10'(x1), 9'(y1)};
  endtask

  task automatic clear_rects();
    for (int i = 0; i < NR; i++) set_rect(i, 0, 0, 0, 0);
  endtask

  // A pixel is a wall if it lies on some rectangle's edge strictly between its corners.
  function automatic bit is_wall(input int px, input int py);
    for (int i = 0; i < NR; i++) begin
      bool_check: begin
        bit on_side   = (px == rx0[i] || px == rx1[i]) && (py > ry0[i] && py < ry1[i]);
        bit on_topbot = (py == ry0[i] || py == ry1[i]) && (px > rx0[i] && px < rx1[i]);
        if (on_side || on_topbot) return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  task automatic push_frame();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        exp_q.push_back('{x: x, y: y, color: is_wall(x, y) ? WALL : BG,
                          last: (x == W - 1) && (y == H - 1)});
  endtask

  task automatic issue_start(input int hold_cycles);
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    push_frame();
    for (int i = 1; i < hold_cycles; i++) begin
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  task automatic wait_frame(input string name);
    bit finished = 0;
    for (int i = 0; i < FRAME_BUDGET; i++) begin
      @(posedge clk);
      if (exp_q.size() == 0 && !expect_done) begin
        finished = 1;
        break;
      end
    end
    check(name, finished, 1'b1);
    if (finished) frames_done++;
    else begin
      exp_q.delete();
      expect_done = 0;
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_valid"}, wr_bus.wr_valid, 1'b0);
    check({tag, "_busy"},  busy, 1'b0);
    check({tag, "_done"},  done, 1'b0);
    check({tag, "_x"},     wr_bus.wr_x, 10'd0);
    check({tag, "_y"},     wr_bus.wr_y, 9'd0);
    check({tag, "_color"}, wr_bus.wr_color, BG);
  endtask

  // Ready driver: 0 = always ready, 1 = toggling, 2 = random with ~75% ready.
  initial begin
    wr_bus.wr_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       wr_bus.wr_ready = 1'b1;
        1:       wr_bus.wr_ready = ~wr_bus.wr_ready;
        default: wr_bus.wr_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor: samples on the falling edge, pops the scoreboard on each accepted write.
  logic [9:0]  prev_x;
  logic [8:0]  prev_y;
  logic [23:0] prev_color;
  bit          prev_stall = 0;

  always @(negedge clk) begin
    if (!reset) begin
      prev_stall = 0;
    end else begin
      check("busy_vs_frame",  busy, exp_q.size() != 0);
      check("valid_vs_frame", wr_bus.wr_valid, exp_q.size() != 0);
      if (done) done_count++;
      if (expect_done) begin
        check("done_pulse", done, 1'b1);
        expect_done = 0;
      end else begin
        check("done_spurious", done, 1'b0);
      end
      if (prev_stall && wr_bus.wr_valid) begin
        check("stall_x",     wr_bus.wr_x, prev_x);
        check("stall_y",     wr_bus.wr_y, prev_y);
        check("stall_color", wr_bus.wr_color, prev_color);
      end
      if (wr_bus.wr_valid && wr_bus.wr_ready && exp_q.size() != 0) begin
        px_t e;
        e = exp_q.pop_front();
        check("pix_x",     wr_bus.wr_x, 10'(e.x));
        check("pix_y",     wr_bus.wr_y, 9'(e.y));
        check("pix_color", wr_bus.wr_color, e.color);
        if (e.last) expect_done = 1;
      end
      prev_stall = wr_bus.wr_valid && !wr_bus.wr_ready;
      prev_x     = wr_bus.wr_x;
      prev_y     = wr_bus.wr_y;
      prev_color = wr_bus.wr_color;
    end
  end

  initial begin
    reset = 1'b0;
    start = 1'b0;
    clear_rects();
    #12;
    check_reset_values("rst");
    #10 reset = 1'b1;

    // Single rectangle, always ready.
    set_rect(0, 10, 20, 30, 40);
    ready_mode = 0;
    issue_start(1);
    wait_frame("frame_single");

    // Overlapping rects plus a thin one, toggling ready.
    set_rect(0, 2, 1, 5, 3);
    set_rect(1, 4, 0, 7, 2);
    set_rect(2, 1, 0, 6, 3);
    set_rect(3, 20, 5, 21, 30);
    ready_mode = 1;
    issue_start(1);
    wait_frame("frame_overlap");

    // Random rectangles with random back-pressure.
    ready_mode = 2;
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < NR; i++)
        set_rect(i, $urandom_range(0, W - 1), $urandom_range(0, H - 1),
                    $urandom_range(0, W + 3), $urandom_range(0, H + 3));
      issue_start(1);
      wait_frame("frame_random");
    end

    // All-zero map, start held three cycles then pulsed again mid-frame.
    clear_rects();
    issue_start(3);
    repeat (50) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_frame("frame_zero");
    repeat (3) @(posedge clk);
    check("no_restart", busy, 1'b0);

    // Asynchronous reset in the middle of a frame, then a clean redraw.
    set_rect(0, 1, 0, 6, 3);
    set_rect(1, 3, 1, 3, 9);
    ready_mode = 2;
    issue_start(1);
    begin
      bit found = 0;
      for (int i = 0; i < FRAME_BUDGET; i++) begin
        @(negedge clk);
        if (wr_bus.wr_valid && wr_bus.wr_x == 10'd3 && wr_bus.wr_y == 9'd2) begin
          found = 1;
          break;
        end
      end
      check("reach_pixel_3_2", found, 1'b1);
    end
    #2 reset = 1'b0;
    exp_q.delete();
    expect_done = 0;
    #1 check_reset_values("midrst");
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    repeat (4) @(posedge clk);
    check("post_reset_idle", busy, 1'b0);
    issue_start(1);
    wait_frame("frame_after_reset");

    check("done_pulses", done_count, frames_done);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
